accum_table_rd_seq: RTL and testbench

Read-out sequencer directly upstream of the accumulator-table read address control. After a matrix multiply completes, it walks every accumulated output row and drives `sub_row` / `submat_row_idx` / `submat_col_idx` into the address control one read per cycle. It then captures the table's registered read data and presents it downstream through a valid/ready stream. A small credit-controlled output FIFO absorbs backpressure without losing in-flight reads.

---
 rtl/tpu_accum_pkg.sv | 31 +++
 rtl/accum_table_rd_seq_if.sv | 39 +++
 rtl/accum_rd_fifo.sv | 63 ++++++
 rtl/accum_table_rd_seq.sv | 151 +++++++++++++++
 tb/tb_accum_table_rd_seq.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_accum_pkg.sv
// rtl/tpu_accum_pkg.sv - shared constants, index widths and state enum for the accumulator read-out path
package tpu_accum_pkg;

  localparam int DEF_MAX_OUT_ROWS = 128;
  localparam int DEF_MAX_OUT_COLS = 128;
  localparam int DEF_SYS_ARR_ROWS = 16;
  localparam int DEF_SYS_ARR_COLS = 16;
  localparam int DEF_ACC_W        = 32;
  localparam int DEF_FIFO_DEPTH   = 4;

  localparam int NUM_ROW_SUB_MAT = DEF_MAX_OUT_ROWS / DEF_SYS_ARR_ROWS;
  localparam int NUM_COL_SUB_MAT = DEF_MAX_OUT_COLS / DEF_SYS_ARR_COLS;
  localparam int NUM_ACCUM_ROWS  = DEF_MAX_OUT_ROWS * NUM_COL_SUB_MAT;

  // Index fields never collapse to zero width, even for a single sub-matrix.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SUB_ROW_W  = idx_w(DEF_SYS_ARR_ROWS);
  localparam int ROW_IDX_W  = idx_w(NUM_ROW_SUB_MAT);
  localparam int COL_IDX_W  = idx_w(NUM_COL_SUB_MAT);
  localparam int ACC_DATA_W = DEF_SYS_ARR_COLS * DEF_ACC_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } accum_rd_state_t;

endpackage

// File: rtl/accum_table_rd_seq_if.sv
// rtl/accum_table_rd_seq_if.sv - job control, table address/data and output stream bundle
interface accum_table_rd_seq_if
  import tpu_accum_pkg::*;
#(
  parameter int SRW = SUB_ROW_W,
  parameter int RW  = ROW_IDX_W,
  parameter int CW  = COL_IDX_W,
  parameter int DW  = ACC_DATA_W
);
  logic          start;
  logic [RW-1:0] num_row_submat;
  logic [CW-1:0] num_col_submat;

  logic [SRW-1:0] sub_row;
  logic [RW-1:0]  submat_row_idx;
  logic [CW-1:0]  submat_col_idx;
  logic           rd_en;
  logic [DW-1:0]  rd_data;

  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  logic busy;
  logic done;

  modport master (
    input  start, num_row_submat, num_col_submat, rd_data, out_ready,
    output sub_row, submat_row_idx, submat_col_idx, rd_en,
    output out_data, out_valid, out_last, busy, done
  );

  modport slave (
    output start, num_row_submat, num_col_submat, rd_data, out_ready,
    input  sub_row, submat_row_idx, submat_col_idx, rd_en,
    input  out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/accum_rd_fifo.sv
// rtl/accum_rd_fifo.sv - small synchronous FIFO holding read data plus last tag, with occupancy count
module accum_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 513
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               push_data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared so the exposed head reads zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/accum_table_rd_seq.sv
// rtl/accum_table_rd_seq.sv - walks accumulator rows, issues credit-limited table reads, streams results
// Optional stall_cycles counter is built when ACCUM_RD_PERF_EN is defined.
module accum_table_rd_seq
  import tpu_accum_pkg::*;
#(
  parameter int MAX_OUT_ROWS = DEF_MAX_OUT_ROWS,
  parameter int MAX_OUT_COLS = DEF_MAX_OUT_COLS,
  parameter int SYS_ARR_ROWS = DEF_SYS_ARR_ROWS,
  parameter int SYS_ARR_COLS = DEF_SYS_ARR_COLS,
  parameter int ACC_W        = DEF_ACC_W,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  accum_table_rd_seq_if.master  bus
`ifdef ACCUM_RD_PERF_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);
  localparam int N_ROW_SM = MAX_OUT_ROWS / SYS_ARR_ROWS;
  localparam int N_COL_SM = MAX_OUT_COLS / SYS_ARR_COLS;
  localparam int SRW      = idx_w(SYS_ARR_ROWS);
  localparam int RW       = idx_w(N_ROW_SM);
  localparam int CW       = idx_w(N_COL_SM);
  localparam int DW       = SYS_ARR_COLS * ACC_W;
  localparam int CNTW     = $clog2(FIFO_DEPTH + 1);

  accum_rd_state_t state_q, state_d;
  logic [SRW-1:0]  sub_row_q, sub_row_d;
  logic [RW-1:0]   row_q, row_d, num_row_q;
  logic [CW-1:0]   col_q, col_d, num_col_q;
  logic            rd_pending_q, pend_last_q;
  logic            rd_en, busy, done;
  logic            start_acc, last_rd, pop, out_valid;
  logic [CNTW-1:0] fifo_count;
  logic [DW:0]     fifo_head;

  assign start_acc = bus.start && (state_q == IDLE);
  assign last_rd   = (col_q == num_col_q) && (sub_row_q == SRW'(SYS_ARR_ROWS - 1)) &&
                     (row_q == num_row_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (rd_en && last_rd) state_d = DRAIN;
      DRAIN:   if (!rd_pending_q && (fifo_count == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A read is only issued when the FIFO can hold it alongside any read still in flight.
  always_comb begin
    rd_en = (state_q == RUN) && ((int'(fifo_count) + int'(rd_pending_q)) < FIFO_DEPTH);
    busy  = (state_q != IDLE);
    done  = (state_q == DRAIN) && !rd_pending_q && (fifo_count == '0);
  end

  always_comb begin
    sub_row_d = sub_row_q;
    row_d     = row_q;
    col_d     = col_q;
    if (start_acc) begin
      sub_row_d = '0;
      row_d     = '0;
      col_d     = '0;
    end else if (rd_en) begin
      if (col_q == num_col_q) begin
        col_d = '0;
        if (sub_row_q == SRW'(SYS_ARR_ROWS - 1)) begin
          sub_row_d = '0;
          row_d     = (row_q == num_row_q) ? '0 : row_q + 1'b1;
        end else begin
          sub_row_d = sub_row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub_row_q    <= '0;
      row_q        <= '0;
      col_q        <= '0;
      num_row_q    <= '0;
      num_col_q    <= '0;
      rd_pending_q <= 1'b0;
      pend_last_q  <= 1'b0;
    end else begin
      sub_row_q    <= sub_row_d;
      row_q        <= row_d;
      col_q        <= col_d;
      rd_pending_q <= rd_en;
      pend_last_q  <= rd_en && last_rd;
      if (start_acc) begin
        num_row_q <= bus.num_row_submat;
        num_col_q <= bus.num_col_submat;
      end
    end
  end

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && bus.out_ready;

  accum_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW + 1)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (rd_pending_q),
    .push_data_i ({pend_last_q, bus.rd_data}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  assign bus.sub_row        = sub_row_q;
  assign bus.submat_row_idx = row_q;
  assign bus.submat_col_idx = col_q;
  assign bus.rd_en          = rd_en;
  assign bus.out_data       = fifo_head[DW-1:0];
  assign bus.out_last       = fifo_head[DW];
  assign bus.out_valid      = out_valid;
  assign bus.busy           = busy;
  assign bus.done           = done;

`ifdef ACCUM_RD_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if (busy && out_valid && !bus.out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_accum_table_rd_seq.sv
// tb/tb_accum_table_rd_seq.sv - scoreboard bench for accum_table_rd_seq with a registered table model
module tb_accum_table_rd_seq;
  import tpu_accum_pkg::*;

  typedef struct {
    logic [ACC_DATA_W-1:0] d;
    logic                  last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  accum_table_rd_seq_if bus ();

`ifdef ACCUM_RD_PERF_EN
  logic [31:0] stall_cycles;
`endif

  accum_table_rd_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
`ifdef ACCUM_RD_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sbq[$];
  int   rd_cnt = 0, beats = 0, first_rd = -1, first_valid = -1, last_beat = -1;
  int   done_cnt = 0, done_cyc = -1, s_cyc = 0;
  int   last_r = -1, last_s = -1, last_c = -1;

  function automatic logic [ACC_DATA_W-1:0] tbl(input int r, input int s, input int c);
    logic [ACC_DATA_W-1:0] v;
    v = '0;
    for (int k = 0; k < DEF_SYS_ARR_COLS; k++) v[k*DEF_ACC_W +: 32] = {8'(k), 8'(r), 8'(s), 8'(c)};
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Accumulator table: registered read data, one cycle after rd_en.
  always @(posedge clk)
    if (bus.rd_en)
      bus.rd_data <= tbl(int'(bus.submat_row_idx), int'(bus.sub_row), int'(bus.submat_col_idx));

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      if (bus.rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        last_r = int'(bus.submat_row_idx);
        last_s = int'(bus.sub_row);
        last_c = int'(bus.submat_col_idx);
      end
      if (bus.out_valid && first_valid < 0) first_valid = cyc;
      if (bus.out_valid && bus.out_ready) begin
        beats++;
        last_beat = cyc;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_extra_beat at cycle %0d: got data=%h last=%0b, required no beat",
                   cyc, bus.out_data, bus.out_last);
        end else begin
          e = sbq.pop_front();
          if (bus.out_data !== e.d || bus.out_last !== e.last) begin
            errors++;
            $display("FAIL sb_beat%0d: got last=%0b data=%h required last=%0b data=%h",
                     beats, bus.out_last, bus.out_data, e.last, e.d);
          end
        end
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic push_job(input int r, input int c);
    for (int ri = 0; ri <= r; ri++)
      for (int s = 0; s < DEF_SYS_ARR_ROWS; s++)
        for (int ci = 0; ci <= c; ci++)
          sbq.push_back('{d: tbl(ri, s, ci),
                          last: (ri == r && s == DEF_SYS_ARR_ROWS - 1 && ci == c)});
  endtask

  task automatic start_job(input int r, input int c, input bit accept);
    @(posedge clk);
    #1;
    if (accept) begin
      push_job(r, c);
      rd_cnt = 0; beats = 0; first_rd = -1; first_valid = -1; last_beat = -1;
      s_cyc = cyc;
    end
    bus.start          = 1'b1;
    bus.num_row_submat = ROW_IDX_W'(r);
    bus.num_col_submat = COL_IDX_W'(c);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
    end
    chk({nm, "_done_seen"}, longint'(seen), 1);
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_rd_en"}, bus.rd_en, 0);
    chk({nm, "_out_valid"}, bus.out_valid, 0);
    chk({nm, "_out_last"}, bus.out_last, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_done"}, bus.done, 0);
    chk({nm, "_sub_row"}, bus.sub_row, 0);
    chk({nm, "_row_idx"}, bus.submat_row_idx, 0);
    chk({nm, "_col_idx"}, bus.submat_col_idx, 0);
    chk({nm, "_out_data_zero"}, longint'(bus.out_data == '0), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit reached;
    bus.start = 1'b0;
    bus.num_row_submat = '0;
    bus.num_col_submat = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("rst");
    reset = 1'b0;

    // Minimal job: R=0, C=0, full throughput.
    start_job(0, 0, 1'b1);
    wait_done(60, "min");
    chk("min_reads", rd_cnt, 16);
    chk("min_first_rd_cycle", first_rd - s_cyc, 1);
    chk("min_first_valid_cycle", first_valid - s_cyc, 3);
    chk("min_last_beat_cycle", last_beat - s_cyc, 18);
    chk("min_done_cycle", done_cyc - s_cyc, 19);
    chk("min_beats", beats, 16);
    chk("min_sb_empty", sbq.size(), 0);
    @(posedge clk);
    #1;
    chk("min_busy_after", bus.busy, 0);

    // Scan order: R=1, C=2.
    start_job(1, 2, 1'b1);
    wait_done(300, "scan");
    chk("scan_reads", rd_cnt, 96);
    chk("scan_final_row", last_r, 1);
    chk("scan_final_sub_row", last_s, 15);
    chk("scan_final_col", last_c, 2);
    chk("scan_sb_empty", sbq.size(), 0);

    // Backpressure from the start of the job.
    bus.out_ready = 1'b0;
    start_job(0, 1, 1'b1);
    repeat (20) @(negedge clk);
    #1;
    chk("bp_reads_held", rd_cnt, 4);
    chk("bp_rd_en_low", bus.rd_en, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    chk("bp_beats", beats, 0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_done(200, "bp");
    chk("bp_total_beats", beats, 32);
    chk("bp_total_reads", rd_cnt, 32);
    chk("bp_sb_empty", sbq.size(), 0);

    // Start while busy must be ignored.
    start_job(0, 0, 1'b1);
    repeat (3) @(posedge clk);
    start_job(1, 1, 1'b0);
    wait_done(200, "busy_start");
    chk("busy_start_reads", rd_cnt, 16);
    chk("busy_start_beats", beats, 16);
    chk("busy_start_sb_empty", sbq.size(), 0);

    // Asynchronous reset in the middle of RUN.
    start_job(1, 0, 1'b1);
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (rd_cnt >= 10) begin
        reached = 1'b1;
        break;
      end
    end
    chk("mid_rst_reached_10_reads", longint'(reached), 1);
    reset = 1'b1;
    #1;
    chk_idle_outputs("mid_rst");
    sbq.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    start_job(0, 0, 1'b1);
    wait_done(60, "post_rst");
    chk("post_rst_reads", rd_cnt, 16);
    chk("post_rst_first_rd_cycle", first_rd - s_cyc, 1);
    chk("post_rst_beats", beats, 16);
    chk("post_rst_sb_empty", sbq.size(), 0);

`ifdef ACCUM_RD_PERF_EN
    bus.out_ready = 1'b0;
    start_job(0, 0, 1'b1);
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("perf_valid_seen", longint'(reached), 1);
    repeat (7) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_done(100, "perf");
    chk("perf_stall_cycles", stall_cycles, 7);
    start_job(0, 0, 1'b1);
    chk("perf_stall_cleared", stall_cycles, 0);
    wait_done(60, "perf2");
    chk("perf2_sb_empty", sbq.size(), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
